// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receiver and transmitter:
//   - uart_state_e : character-framing FSM states
//   - PT_NONE / PT_EVEN / PT_ODD : parity-type selectors, stored as 32-bit
//     ASCII codes so that a string parameter can be compared directly
//   - parity_bit() : expected parity bit for a given data XOR
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic [31:0] PT_NONE = "NONE";
    localparam logic [31:0] PT_EVEN = "EVEN";
    localparam logic [31:0] PT_ODD  = {8'h00, "ODD"};

    // EVEN parity transmits the XOR of the data bits, ODD its inverse.
    function automatic logic parity_bit(input logic [31:0] pt, input logic dataXor);
        return (pt == PT_ODD) ? ~dataXor : dataXor;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
// Multi-stage flip-flop synchronizer for a single asynchronous input.
// Ports:
//   clk_i : clock
//   rst_i : synchronous active-high reset, loads RST_VAL into every stage
//   d_i   : asynchronous input
//   q_o   : synchronized output
// ---------------------------------------------------------------------------
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through the chain; only the last stage is used.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART receiver with optional parity, 1 or 2 stop bits and an AXI-Stream
// style single-entry output register.
// Parameters:
//   DW : data bits per character
//   PT : parity type, "NONE", "EVEN" or "ODD"
//   SW : stop bits, 1 or 2
//   BN : clock cycles per bit period (>= 4)
// Ports:
//   clk            : clock, all logic on the rising edge
//   rst            : synchronous active-high reset
//   uart_rxd       : asynchronous serial line, idle high
//   str_rxd_tvalid : received character valid
//   str_rxd_tdata  : received character
//   str_rxd_tready : downstream accepts the character
//   error_fifo     : one-cycle pulse, character dropped because output full
//   error_parity   : one-cycle pulse with tvalid rise, parity mismatch
//   error_frame    : one-cycle pulse, a stop bit was sampled low
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int          DW = 8,
    parameter logic [31:0] PT = "NONE",
    parameter int          SW = 1,
    parameter int          BN = 54
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          uart_rxd,
    output logic          str_rxd_tvalid,
    output logic [DW-1:0] str_rxd_tdata,
    input  logic          str_rxd_tready,
    output logic          error_fifo,
    output logic          error_parity,
    output logic          error_frame
);

    localparam int              CW         = $clog2(BN);
    localparam int              BW         = $clog2(DW + 1);
    localparam logic [CW-1:0]   CNT_LAST   = CW'(BN - 1);
    localparam logic [CW-1:0]   CNT_HALF   = CW'(BN / 2 - 1);
    localparam logic [BW-1:0]   BIT_LAST   = BW'(DW - 1);
    localparam logic            STOP_LAST  = (SW == 2);
    localparam bit              HAS_PARITY = (PT != PT_NONE);

    logic          rxdS;

    uart_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bitCnt_q, bitCnt_d;
    logic          stopCnt_q, stopCnt_d;
    logic [DW-1:0] shift_q, shift_d;
    logic          parErr_q, parErr_d;
    logic          stopErr_q, stopErr_d;
    logic          rearm_q, rearm_d;

    logic          tvalid_q;
    logic [DW-1:0] tdata_q;
    logic          errFifo_q, errPar_q, errFrame_q;

    logic          tick;
    logic          charDone;
    logic          frameBad;

    sync_ff #(
        .STAGES  (2),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (uart_rxd),
        .q_o   (rxdS)
    );

    // Once a start bit is qualified the counter is restarted, so every
    // later tick lands one full bit period after the mid-start sample.
    assign tick = (cnt_q == CNT_LAST);

    // Next-state and datapath decode for the framing FSM.
    always_comb begin
        state_d   = state_q;
        bitCnt_d  = bitCnt_q;
        stopCnt_d = stopCnt_q;
        shift_d   = shift_q;
        parErr_d  = parErr_q;
        stopErr_d = stopErr_q;
        rearm_d   = rearm_q;
        charDone  = 1'b0;
        frameBad  = 1'b0;

        // After a framing error the line may still be low; hold off start
        // detection until it has been seen high again.
        if (rxdS) begin
            rearm_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                bitCnt_d  = '0;
                stopCnt_d = 1'b0;
                parErr_d  = 1'b0;
                stopErr_d = 1'b0;
                if (!rxdS && !rearm_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    state_d = rxdS ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d  = DW'({rxdS, shift_q} >> 1);
                    bitCnt_d = bitCnt_q + 1'b1;
                    if (bitCnt_q == BIT_LAST) begin
                        state_d = HAS_PARITY ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    parErr_d = (rxdS != parity_bit(PT, ^shift_q));
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    stopCnt_d = stopCnt_q + 1'b1;
                    if (!rxdS) begin
                        stopErr_d = 1'b1;
                    end
                    if (stopCnt_q == STOP_LAST) begin
                        charDone = 1'b1;
                        frameBad = stopErr_q | ~rxdS;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (charDone && frameBad) begin
            rearm_d = 1'b1;
        end
    end

    // Baud counter: free-running modulo BN, restarted on every state change
    // and parked at zero while idle.
    always_comb begin
        if (state_d != state_q || state_q == IDLE || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bitCnt_q  <= '0;
            stopCnt_q <= 1'b0;
            shift_q   <= '0;
            parErr_q  <= 1'b0;
            stopErr_q <= 1'b0;
            rearm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitCnt_q  <= bitCnt_d;
            stopCnt_q <= stopCnt_d;
            shift_q   <= shift_d;
            parErr_q  <= parErr_d;
            stopErr_q <= stopErr_d;
            rearm_q   <= rearm_d;
        end
    end

    // Output register and error pulses. A completion that coincides with
    // acceptance reloads the register, so it is not an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            errFifo_q  <= 1'b0;
            errPar_q   <= 1'b0;
            errFrame_q <= 1'b0;
        end else begin
            errFifo_q  <= 1'b0;
            errPar_q   <= 1'b0;
            errFrame_q <= 1'b0;
            if (tvalid_q && str_rxd_tready) begin
                tvalid_q <= 1'b0;
            end
            if (charDone) begin
                if (frameBad) begin
                    errFrame_q <= 1'b1;
                end else if (tvalid_q && !str_rxd_tready) begin
                    errFifo_q <= 1'b1;
                end else begin
                    tvalid_q <= 1'b1;
                    tdata_q  <= shift_q;
                    errPar_q <= parErr_q;
                end
            end
        end
    end

    assign str_rxd_tvalid = tvalid_q;
    assign str_rxd_tdata  = tdata_q;
    assign error_fifo     = errFifo_q;
    assign error_parity   = errPar_q;
    assign error_frame    = errFrame_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Three receivers share clock and reset:
//   dut0 : PT="NONE", SW=1
//   dut1 : PT="EVEN", SW=1
//   dut2 : PT="NONE", SW=2
// A serial model drives each line; a negedge monitor counts accepted
// characters and error-pulse cycles per receiver.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BN   = 54;
    localparam int NDUT = 3;
    localparam int NVEC = 11;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd    [NDUT];
    logic       tready [NDUT];
    logic       tvalid [NDUT];
    logic [7:0] tdata  [NDUT];
    logic       eFifo  [NDUT];
    logic       ePar   [NDUT];
    logic       eFrame [NDUT];

    int nChecks = 0;
    int nFails  = 0;

    int         accCnt   [NDUT];
    int         parCnt   [NDUT];
    int         parCoinc [NDUT];
    int         frameCnt [NDUT];
    int         fifoCnt  [NDUT];
    logic [7:0] lastData [NDUT];
    logic       prevValid[NDUT];
    logic [7:0] accLog2  [$];

    always #5 clk = ~clk;

    uart_rx #(.DW(8), .PT("NONE"), .SW(1), .BN(BN)) dut0 (
        .clk(clk), .rst(rst), .uart_rxd(rxd[0]),
        .str_rxd_tvalid(tvalid[0]), .str_rxd_tdata(tdata[0]), .str_rxd_tready(tready[0]),
        .error_fifo(eFifo[0]), .error_parity(ePar[0]), .error_frame(eFrame[0]));

    uart_rx #(.DW(8), .PT("EVEN"), .SW(1), .BN(BN)) dut1 (
        .clk(clk), .rst(rst), .uart_rxd(rxd[1]),
        .str_rxd_tvalid(tvalid[1]), .str_rxd_tdata(tdata[1]), .str_rxd_tready(tready[1]),
        .error_fifo(eFifo[1]), .error_parity(ePar[1]), .error_frame(eFrame[1]));

    uart_rx #(.DW(8), .PT("NONE"), .SW(2), .BN(BN)) dut2 (
        .clk(clk), .rst(rst), .uart_rxd(rxd[2]),
        .str_rxd_tvalid(tvalid[2]), .str_rxd_tdata(tdata[2]), .str_rxd_tready(tready[2]),
        .error_fifo(eFifo[2]), .error_parity(ePar[2]), .error_frame(eFrame[2]));

    // Monitor: every high cycle of an error output is counted, so a pulse
    // that is held longer than one cycle shows up as an extra count.
    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (tvalid[k] === 1'b1 && tready[k] === 1'b1) begin
                accCnt[k]++;
                lastData[k] = tdata[k];
                if (k == 2) accLog2.push_back(tdata[k]);
            end
            if (ePar[k] === 1'b1) begin
                parCnt[k]++;
                if (tvalid[k] === 1'b1 && prevValid[k] === 1'b0) parCoinc[k]++;
            end
            if (eFrame[k] === 1'b1) frameCnt[k]++;
            if (eFifo[k] === 1'b1) fifoCnt[k]++;
            prevValid[k] = tvalid[k];
        end
    end

    typedef struct {
        int         dut;
        logic [7:0] data;
        int         parMode;   // 0 none, 1 correct, 2 inverted
        int         stopBad;   // 0 none, else index of the stop bit sent low
        int         expAcc;
        logic [7:0] expData;
        int         expPar;
        int         expFrame;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Callers are always at posedge+1 when a task starts and when it returns.
    task automatic driveBit(input int k, input logic b);
        rxd[k] = b;
        repeat (BN) @(posedge clk);
        #1;
    endtask

    task automatic sendFrame(input int k, input logic [7:0] data, input int parMode,
                             input int stopBad, input int nStop, input int idleBits);
        driveBit(k, 1'b0);
        for (int i = 0; i < 8; i++) driveBit(k, data[i]);
        if (parMode != 0) driveBit(k, (^data) ^ (parMode == 2));
        for (int s = 1; s <= nStop; s++) driveBit(k, (stopBad == s) ? 1'b0 : 1'b1);
        for (int i = 0; i < idleBits; i++) driveBit(k, 1'b1);
    endtask

    task automatic applyStimulus(input vec_t v);
        sendFrame(v.dut, v.data, v.parMode, v.stopBad, (v.dut == 2) ? 2 : 1, 2);
    endtask

    initial begin
        int a0, p0, c0, f0, o0, base;
        logic [7:0] b2b [3];

        vecs[0]  = '{0, 8'hA5, 0, 0, 1, 8'hA5, 0, 0};
        vecs[1]  = '{1, 8'h3C, 2, 0, 1, 8'h3C, 1, 0};
        vecs[2]  = '{1, 8'h3C, 1, 0, 1, 8'h3C, 0, 0};
        vecs[3]  = '{1, 8'h01, 2, 0, 1, 8'h01, 1, 0};
        vecs[4]  = '{1, 8'hE7, 1, 0, 1, 8'hE7, 0, 0};
        vecs[5]  = '{0, 8'h77, 0, 1, 0, 8'h00, 0, 1};
        vecs[6]  = '{0, 8'hFF, 0, 0, 1, 8'hFF, 0, 0};
        vecs[7]  = '{0, 8'h00, 0, 0, 1, 8'h00, 0, 0};
        vecs[8]  = '{2, 8'h96, 0, 0, 1, 8'h96, 0, 0};
        vecs[9]  = '{2, 8'h41, 0, 2, 0, 8'h00, 0, 1};
        vecs[10] = '{2, 8'h41, 0, 1, 0, 8'h00, 0, 1};
        b2b[0] = 8'h12;
        b2b[1] = 8'h34;
        b2b[2] = 8'h56;

        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            rxd[k]    = 1'b1;
            tready[k] = 1'b1;
        end
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("reset tvalid dut%0d", k), 32'(tvalid[k]), 32'd0);
            checkOutput($sformatf("reset tdata dut%0d", k), 32'(tdata[k]), 32'd0);
            checkOutput($sformatf("reset errors dut%0d", k),
                        32'({eFifo[k], ePar[k], eFrame[k]}), 32'd0);
        end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Table-driven single characters with tready held high.
        for (int i = 0; i < NVEC; i++) begin
            int k;
            k  = vecs[i].dut;
            a0 = accCnt[k];  p0 = parCnt[k];  c0 = parCoinc[k];
            f0 = frameCnt[k]; o0 = fifoCnt[k];
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d accepted", i), accCnt[k] - a0, vecs[i].expAcc);
            if (vecs[i].expAcc != 0)
                checkOutput($sformatf("vec%0d data", i), 32'(lastData[k]), 32'(vecs[i].expData));
            checkOutput($sformatf("vec%0d parity pulses", i), parCnt[k] - p0, vecs[i].expPar);
            checkOutput($sformatf("vec%0d parity with tvalid rise", i), parCoinc[k] - c0, vecs[i].expPar);
            checkOutput($sformatf("vec%0d frame pulses", i), frameCnt[k] - f0, vecs[i].expFrame);
            checkOutput($sformatf("vec%0d fifo pulses", i), fifoCnt[k] - o0, 0);
        end

        // Overrun: second character dropped while the first is held.
        tready[0] = 1'b0;
        a0 = accCnt[0]; o0 = fifoCnt[0];
        sendFrame(0, 8'h11, 0, 0, 1, 2);
        checkOutput("ovr first tvalid", 32'(tvalid[0]), 32'd1);
        checkOutput("ovr first tdata", 32'(tdata[0]), 32'h11);
        sendFrame(0, 8'h22, 0, 0, 1, 2);
        checkOutput("ovr held tvalid", 32'(tvalid[0]), 32'd1);
        checkOutput("ovr held tdata", 32'(tdata[0]), 32'h11);
        checkOutput("ovr fifo pulses", fifoCnt[0] - o0, 1);
        checkOutput("ovr none accepted", accCnt[0] - a0, 0);
        tready[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ovr one transfer", accCnt[0] - a0, 1);
        checkOutput("ovr transfer data", 32'(lastData[0]), 32'h11);
        checkOutput("ovr tvalid cleared", 32'(tvalid[0]), 32'd0);

        // Short low glitch must not produce a character.
        a0 = accCnt[0]; f0 = frameCnt[0];
        rxd[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rxd[0] = 1'b1;
        repeat (2 * BN) @(posedge clk);
        #1;
        checkOutput("glitch no output", accCnt[0] - a0, 0);
        sendFrame(0, 8'h5A, 0, 0, 1, 2);
        checkOutput("glitch then one char", accCnt[0] - a0, 1);
        checkOutput("glitch then data", 32'(lastData[0]), 32'h5A);
        checkOutput("glitch frame pulses", frameCnt[0] - f0, 0);

        // Reset during bit 4 of 0x81 abandons it silently.
        a0 = accCnt[0]; f0 = frameCnt[0]; p0 = parCnt[0]; o0 = fifoCnt[0];
        driveBit(0, 1'b0);
        for (int i = 0; i < 4; i++) driveBit(0, 8'h81 >> i);
        rxd[0] = 1'b0;
        repeat (BN / 2) @(posedge clk);
        #1;
        rst    = 1'b1;
        rxd[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2 * BN) @(posedge clk);
        #1;
        checkOutput("rst mid-char no output", accCnt[0] - a0, 0);
        sendFrame(0, 8'hC3, 0, 0, 1, 2);
        checkOutput("rst then one char", accCnt[0] - a0, 1);
        checkOutput("rst then data", 32'(lastData[0]), 32'hC3);
        checkOutput("rst error pulses", (frameCnt[0] - f0) + (parCnt[0] - p0) + (fifoCnt[0] - o0), 0);

        // Back-to-back characters with two stop bits.
        base = accLog2.size();
        f0   = frameCnt[2];
        sendFrame(2, b2b[0], 0, 0, 2, 0);
        sendFrame(2, b2b[1], 0, 0, 2, 0);
        sendFrame(2, b2b[2], 0, 0, 2, 2);
        checkOutput("b2b count", accLog2.size() - base, 3);
        for (int j = 0; j < 3; j++) begin
            logic [7:0] got;
            got = (accLog2.size() > base + j) ? accLog2[base + j] : 8'hXX;
            checkOutput($sformatf("b2b char%0d", j), 32'(got), 32'(b2b[j]));
        end
        checkOutput("b2b frame pulses", frameCnt[2] - f0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
